// File: rtl/fsm_batch_pkg.sv
// Shared encodings for the batch engine: FSM states and per-element operation modes.
package fsm_batch_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    GET_DATA = 3'd1,
    PROCESS  = 3'd2,
    OUTPUT   = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    ADD_IDX = 2'd1,
    REVERSE = 2'd2,
    SAT_DBL = 2'd3
  } mode_e;

endpackage

// File: rtl/batch_alu.sv
// Combinational per-element operation applied to each buffered word during PROCESS.
module batch_alu
  import fsm_batch_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 4
) (
  input  logic [DATA_W-1:0] x,
  input  logic [CNT_W-1:0]  idx,
  input  mode_e             mode,
  output logic [DATA_W-1:0] y
);

  // Sum is formed at the wider of the two widths so the index is never truncated before the add.
  localparam int SUM_W = (DATA_W > CNT_W) ? DATA_W : CNT_W;

  logic [SUM_W-1:0] sum;

  assign sum = SUM_W'(x) + SUM_W'(idx);

  always_comb begin
    y = x;
    case (mode)
      ADD_IDX: y = sum[DATA_W-1:0];
      SAT_DBL: y = x[DATA_W-1] ? {DATA_W{1'b1}} : {x[DATA_W-2:0], 1'b0};
      default: y = x;
    endcase
  end

endmodule

// File: rtl/fsm_batch_engine.sv
// Collect DEPTH words, transform each in place by mode, then stream them out with backpressure.
// Handshake: a word moves on any rising edge where valid && ready; ready/valid depend only on state.
module fsm_batch_engine
  import fsm_batch_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  offset_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mode_e              mode_q, mode_d;
  logic               done_q, done_d;

  logic [DATA_W-1:0]  buf_q [DEPTH];
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]  alu_y;
  logic [CNT_W-1:0]   rd_cnt;

  batch_alu #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_alu (
    .x    (buf_q[cnt_q[IDX_W-1:0]]),
    .idx  (cnt_q),
    .mode (mode_q),
    .y    (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      mode_q  <= PASS;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) buf_q[wr_idx] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cnt_q[IDX_W-1:0];
    wr_data = in_data;
    case (state_q)
      INIT: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          mode_d  = mode_e'(mode);
          cnt_d   = CNT_W'(1);
          state_d = GET_DATA;
        end
      end
      GET_DATA: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = PROCESS;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PROCESS: begin
        wr_en   = 1'b1;
        wr_data = alu_y;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = INIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = INIT;
      end
    endcase
  end

  assign rd_cnt     = (mode_q == REVERSE) ? (LAST - cnt_q) : cnt_q;
  assign in_ready   = (state_q == INIT) || (state_q == GET_DATA);
  assign out_valid  = (state_q == OUTPUT);
  assign out_data   = out_valid ? buf_q[rd_cnt[IDX_W-1:0]] : '0;
  assign done       = done_q;
  assign state      = state_q;
  assign offset_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_batch_engine.sv
// Directed bench for fsm_batch_engine at DATA_W=6, DEPTH=8 with hand-computed expected batches.
module tb_fsm_batch_engine;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [1:0]        mode;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              done;
  logic [2:0]        state;
  logic [CNT_W-1:0]  offset_cnt;

  fsm_batch_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done       (done),
    .state      (state),
    .offset_cnt (offset_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int done_seen = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_seen <= done_seen + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] din  [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  int hs_cyc;
  int valid_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic [1:0] m, input int gap, input bit first);
    int budget = 0;
    repeat (gap) tick();
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    while (!in_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
    if (first) hs_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int budget = 0;
    while (!out_valid && budget < 60) begin
      tick();
      budget++;
    end
    check("out_valid_timeout", 32'(out_valid), 1);
    valid_cyc = cyc;
  endtask

  task automatic recv_word(input int stall);
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] exp;
    wait_out_valid();
    held = out_data;
    out_ready = 1'b0;
    repeat (stall) begin
      tick();
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_out_data", 32'(out_data), 32'(held));
      check("stall_in_ready", 32'(in_ready), 0);
    end
    exp = exp_q.pop_front();
    check("out_data", 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic send_batch(input logic [1:0] m_first, input logic [1:0] m_rest, input int gap_max);
    for (int i = 0; i < DEPTH; i++)
      send_word(din[i], (i == 0) ? m_first : m_rest, $urandom_range(0, gap_max), (i == 0));
    check("post_send_state", 32'(state), 2);
    check("post_send_in_ready", 32'(in_ready), 0);
  endtask

  task automatic recv_batch(input int stall);
    int done_before;
    done_before = done_seen;
    for (int i = 0; i < DEPTH; i++) recv_word(stall);
    check("done_pulse", 32'(done), 1);
    check("done_state_init", 32'(state), 0);
    check("done_in_ready", 32'(in_ready), 1);
    tick();
    check("done_clear", 32'(done), 0);
    check("done_once", 32'(done_seen - done_before), 1);
  endtask

  task automatic load_t1();
    for (int i = 0; i < DEPTH; i++) begin
      din[i] = DATA_W'(i + 1);
      exp_q.push_back(DATA_W'(i + 1));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_state", 32'(state), 0);
    check("rst_cnt", 32'(offset_cnt), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_state", 32'(state), 0);
    check("reset_cnt", 32'(offset_cnt), 0);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_done", 32'(done), 0);
    check("reset_in_ready", 32'(in_ready), 1);

    // T1: PASS, contiguous, latency from first handshake sample to out_valid is 16 cycles
    load_t1();
    send_batch(2'd0, 2'd0, 0);
    wait_out_valid();
    check("t1_latency", 32'(valid_cyc - hs_cyc), 16);
    recv_batch(0);

    // T2: ADD_IDX with all-ones input wraps
    for (int i = 0; i < DEPTH; i++) din[i] = 6'd63;
    exp_q = '{6'd63, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6};
    send_batch(2'd1, 2'd1, 0);
    recv_batch(0);

    // T3: REVERSE; mode changes to PASS after the first word and must be ignored
    for (int i = 0; i < DEPTH; i++) din[i] = DATA_W'(10 + i);
    exp_q = '{6'd17, 6'd16, 6'd15, 6'd14, 6'd13, 6'd12, 6'd11, 6'd10};
    send_batch(2'd2, 2'd0, 0);
    recv_batch(0);

    // T4: SAT_DBL saturates at 63
    din = '{6'd0, 6'd1, 6'd31, 6'd32, 6'd40, 6'd63, 6'd5, 6'd20};
    exp_q = '{6'd0, 6'd2, 6'd62, 6'd63, 6'd63, 6'd63, 6'd10, 6'd40};
    send_batch(2'd3, 2'd3, 0);
    recv_batch(0);

    // T5: random input gaps, 3 stall cycles per output word
    load_t1();
    send_batch(2'd0, 2'd0, 3);
    recv_batch(3);

    // T6: reset in GET_DATA at cnt=4, then in OUTPUT at cnt=2, then a clean batch
    for (int i = 0; i < 4; i++) send_word(DATA_W'(i + 1), 2'd1, 0, (i == 0));
    check("t6_get_state", 32'(state), 1);
    check("t6_get_cnt", 32'(offset_cnt), 4);
    pulse_reset();

    load_t1();
    send_batch(2'd0, 2'd0, 0);
    recv_word(0);
    recv_word(0);
    check("t6_out_state", 32'(state), 3);
    check("t6_out_cnt", 32'(offset_cnt), 2);
    exp_q.delete();
    pulse_reset();

    load_t1();
    send_batch(2'd0, 2'd0, 0);
    recv_batch(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
